// File: rtl/instruction_fetch.sv
// Instruction fetch: assembles 3-byte instructions from 8-bit program memory
// into a 24-bit CBUS word; owns the PC and applies branch redirects.
module instruction_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_RD,
  input  logic [7:0]  MEM_DATA,
  input  logic        MEM_READY,
  output logic [23:0] CBUS,
  output logic        CBUS_VALID,
  input  logic        HOLD,
  input  logic        JMP_EN,
  input  logic [15:0] JMP_ADDR,
  output logic [15:0] PC
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 3 * BYTE_W;

  typedef enum logic [1:0] {
    F0    = 2'd0,
    F1    = 2'd1,
    F2    = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fa_q, fa_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [BYTE_W-1:0]   b0_q, b0_d;
  logic [BYTE_W-1:0]   b1_q, b1_d;
  logic [WORD_W-1:0]   cbus_q, cbus_d;
  logic                valid_q, valid_d;
  logic                rd_q, rd_d;
  logic                accept;

  // Read strobe is its own register so it is low through reset without any
  // input-to-output path; the first cycle after reset is therefore idle.
  assign accept     = rd_q & MEM_READY;
  assign MEM_ADDR   = fa_q;
  assign MEM_RD     = rd_q;
  assign CBUS       = cbus_q;
  assign CBUS_VALID = valid_q;
  assign PC         = pc_q;

  // Next-state and datapath updates; redirect outranks everything but reset.
  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    pc_d    = pc_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    cbus_d  = cbus_q;
    valid_d = valid_q;

    if (JMP_EN) begin
      state_d = F0;
      fa_d    = JMP_ADDR;
      pc_d    = JMP_ADDR;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        F0: begin
          if (accept) begin
            b0_d    = MEM_DATA;
            fa_d    = fa_q + ADDR_W'(1);
            state_d = F1;
          end
        end
        F1: begin
          if (accept) begin
            b1_d    = MEM_DATA;
            fa_d    = fa_q + ADDR_W'(1);
            state_d = F2;
          end
        end
        F2: begin
          if (accept) begin
            cbus_d  = {b0_q, b1_q, MEM_DATA};
            fa_d    = fa_q + ADDR_W'(1);
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (!HOLD) begin
            valid_d = 1'b0;
            pc_d    = fa_q;
            state_d = F0;
          end
        end
        default: state_d = F0;
      endcase
    end

    rd_d = (state_d != ISSUE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= F0;
      fa_q    <= RESET_VECTOR;
      pc_q    <= RESET_VECTOR;
      b0_q    <= '0;
      b1_q    <= '0;
      cbus_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      pc_q    <= pc_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      cbus_q  <= cbus_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: main instance against a byte memory,
// plus a second instance with RESET_VECTOR=FFFE for address wrap.
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic [7:0]  MEM_DATA;
  logic        MEM_READY;
  logic [23:0] CBUS;
  logic        CBUS_VALID;
  logic        HOLD;
  logic        JMP_EN;
  logic [15:0] JMP_ADDR;
  logic [15:0] PC;

  logic [15:0] w_addr;
  logic        w_rd;
  logic [7:0]  w_data;
  logic [23:0] w_cbus;
  logic        w_valid;
  logic [15:0] w_pc;

  logic [7:0]  mem [65536];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign MEM_DATA = mem[MEM_ADDR];

  always_comb begin
    case (w_addr)
      16'hFFFE: w_data = 8'hAA;
      16'hFFFF: w_data = 8'hBB;
      16'h0000: w_data = 8'hCC;
      default:  w_data = 8'h00;
    endcase
  end

  instruction_fetch dut (
    .CLK(CLK), .RST(RST), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY), .CBUS(CBUS),
    .CBUS_VALID(CBUS_VALID), .HOLD(HOLD), .JMP_EN(JMP_EN),
    .JMP_ADDR(JMP_ADDR), .PC(PC)
  );

  instruction_fetch #(.RESET_VECTOR(16'hFFFE)) dut_wrap (
    .CLK(CLK), .RST(RST), .MEM_ADDR(w_addr), .MEM_RD(w_rd),
    .MEM_DATA(w_data), .MEM_READY(1'b1), .CBUS(w_cbus),
    .CBUS_VALID(w_valid), .HOLD(1'b0), .JMP_EN(1'b0),
    .JMP_ADDR(16'h0000), .PC(w_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h21; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    mem[16'h0003] = 8'h40; mem[16'h0004] = 8'h00; mem[16'h0005] = 8'h07;
    mem[16'h1234] = 8'hDE; mem[16'h1235] = 8'hAD; mem[16'h1236] = 8'hBE;

    RST = 1'b1; MEM_READY = 1'b1; HOLD = 1'b0; JMP_EN = 1'b0; JMP_ADDR = 16'h0000;

    // Reset held two cycles with memory ready
    step(2);
    chk("rst_cbus",  32'(CBUS), 32'h000000);
    chk("rst_valid", 32'(CBUS_VALID), 32'h0);
    chk("rst_pc",    32'(PC), 32'h0000);
    chk("rst_addr",  32'(MEM_ADDR), 32'h0000);
    chk("rst_rd",    32'(MEM_RD), 32'h0);
    chk("rst_w_pc",  32'(w_pc), 32'hFFFE);
    RST = 1'b0;

    // Straight line: edges counted from reset release
    step(1);
    chk("sl_rd_e1",   32'(MEM_RD), 32'h1);
    chk("sl_addr_e1", 32'(MEM_ADDR), 32'h0000);
    step(1);
    chk("sl_addr_e2", 32'(MEM_ADDR), 32'h0001);
    chk("sl_valid_e2", 32'(CBUS_VALID), 32'h0);
    step(1);
    chk("sl_addr_e3", 32'(MEM_ADDR), 32'h0002);
    step(1);
    chk("sl_valid_e4", 32'(CBUS_VALID), 32'h1);
    chk("sl_cbus_e4",  32'(CBUS), 32'h211234);
    chk("sl_pc_e4",    32'(PC), 32'h0000);
    chk("sl_rd_e4",    32'(MEM_RD), 32'h0);
    chk("wr_valid",    32'(w_valid), 32'h1);
    chk("wr_cbus",     32'(w_cbus), 32'hAABBCC);
    chk("wr_pc",       32'(w_pc), 32'hFFFE);
    step(1);
    chk("sl_valid_e5", 32'(CBUS_VALID), 32'h0);
    chk("sl_pc_e5",    32'(PC), 32'h0003);
    chk("sl_addr_e5",  32'(MEM_ADDR), 32'h0003);
    chk("wr_addr_next", 32'(w_addr), 32'h0001);
    chk("wr_pc_next",   32'(w_pc), 32'h0001);
    step(1);
    chk("sl_addr_e6", 32'(MEM_ADDR), 32'h0004);
    step(1);
    chk("sl_addr_e7", 32'(MEM_ADDR), 32'h0005);
    chk("sl_valid_e7", 32'(CBUS_VALID), 32'h0);
    step(1);
    chk("sl_valid_e8", 32'(CBUS_VALID), 32'h1);
    chk("sl_cbus_e8",  32'(CBUS), 32'h400007);
    chk("sl_pc_e8",    32'(PC), 32'h0003);
    step(1);
    chk("sl_pc_e9",    32'(PC), 32'h0006);

    // Mid-fetch reset, then two wait states on byte1
    RST = 1'b1;
    step(1);
    chk("rst2_rd",    32'(MEM_RD), 32'h0);
    chk("rst2_pc",    32'(PC), 32'h0000);
    chk("rst2_valid", 32'(CBUS_VALID), 32'h0);
    RST = 1'b0;
    step(2);
    chk("ws_addr_b1", 32'(MEM_ADDR), 32'h0001);
    MEM_READY = 1'b0;
    step(1);
    chk("ws_hold_addr1", 32'(MEM_ADDR), 32'h0001);
    chk("ws_hold_rd1",   32'(MEM_RD), 32'h1);
    step(1);
    chk("ws_hold_addr2", 32'(MEM_ADDR), 32'h0001);
    chk("ws_hold_rd2",   32'(MEM_RD), 32'h1);
    chk("ws_valid_e4",   32'(CBUS_VALID), 32'h0);
    MEM_READY = 1'b1;
    step(1);
    chk("ws_addr_b2",  32'(MEM_ADDR), 32'h0002);
    chk("ws_valid_e5", 32'(CBUS_VALID), 32'h0);
    step(1);
    chk("ws_valid_e6", 32'(CBUS_VALID), 32'h1);
    chk("ws_cbus_e6",  32'(CBUS), 32'h211234);

    // HOLD three cycles in ISSUE
    HOLD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("hold_valid", 32'(CBUS_VALID), 32'h1);
      chk("hold_cbus",  32'(CBUS), 32'h211234);
      chk("hold_rd",    32'(MEM_RD), 32'h0);
      chk("hold_pc",    32'(PC), 32'h0000);
    end
    HOLD = 1'b0;
    step(1);
    chk("hold_rel_valid", 32'(CBUS_VALID), 32'h0);
    chk("hold_rel_addr",  32'(MEM_ADDR), 32'h0003);
    chk("hold_rel_pc",    32'(PC), 32'h0003);

    // Redirect while in F1
    step(1);
    chk("jf1_addr_pre", 32'(MEM_ADDR), 32'h0004);
    JMP_EN = 1'b1; JMP_ADDR = 16'h1234;
    step(1);
    JMP_EN = 1'b0;
    chk("jf1_addr", 32'(MEM_ADDR), 32'h1234);
    chk("jf1_pc",   32'(PC), 32'h1234);
    chk("jf1_rd",   32'(MEM_RD), 32'h1);
    step(2);
    chk("jf1_valid_pre", 32'(CBUS_VALID), 32'h0);
    step(1);
    chk("jf1_valid", 32'(CBUS_VALID), 32'h1);
    chk("jf1_cbus",  32'(CBUS), 32'hDEADBE);
    chk("jf1_pc2",   32'(PC), 32'h1234);

    // Redirect during ISSUE overrides HOLD; CBUS keeps old word
    HOLD = 1'b1; JMP_EN = 1'b1; JMP_ADDR = 16'h0000;
    step(1);
    HOLD = 1'b0; JMP_EN = 1'b0;
    chk("jis_valid", 32'(CBUS_VALID), 32'h0);
    chk("jis_pc",    32'(PC), 32'h0000);
    chk("jis_addr",  32'(MEM_ADDR), 32'h0000);
    chk("jis_cbus",  32'(CBUS), 32'hDEADBE);

    // Redirect and MEM_READY together in F2: no issue
    step(2);
    chk("jf2_addr_pre", 32'(MEM_ADDR), 32'h0002);
    JMP_EN = 1'b1; JMP_ADDR = 16'h0003;
    step(1);
    JMP_EN = 1'b0;
    chk("jf2_valid", 32'(CBUS_VALID), 32'h0);
    chk("jf2_pc",    32'(PC), 32'h0003);
    chk("jf2_addr",  32'(MEM_ADDR), 32'h0003);
    chk("jf2_cbus",  32'(CBUS), 32'hDEADBE);
    step(3);
    chk("jf2_valid_next", 32'(CBUS_VALID), 32'h1);
    chk("jf2_cbus_next",  32'(CBUS), 32'h400007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
